// File: rtl/usb_data_buffer.sv
// usb_data_buffer: shared 64-byte byte FIFO between usb_rx/usb_tx and the AHB-lite slave.
// Either producer may push, either consumer may pop, and flush/clear empties the FIFO
// without touching the stored bytes. The head byte is shown first-word-fall-through.
module usb_data_buffer #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned OCC_W = 7
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             store_rx_packet_data,
  input  logic [7:0]       rx_packet_data,
  input  logic             flush,
  input  logic             store_tx_data,
  input  logic [7:0]       tx_data,
  input  logic             clear,
  input  logic             get_rx_data,
  input  logic             get_tx_packet_data,
  output logic [7:0]       rx_data,
  output logic [7:0]       tx_packet_data,
  output logic [OCC_W-1:0] buffer_occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);

  logic [7:0]       mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  logic       push_req_c, pop_req_c, flush_req_c;
  logic       empty_c, full_c;
  logic       pop_ok_c, push_ok_c, wr_en_c;
  logic [7:0] wdata_c;
  logic [7:0] head_c;

  // Request decode: rx byte wins over tx byte; a pop on empty is dropped, and a push
  // on full is accepted only when a pop frees a slot in the same cycle.
  always_comb begin
    push_req_c  = store_rx_packet_data | store_tx_data;
    pop_req_c   = get_rx_data | get_tx_packet_data;
    flush_req_c = flush | clear;
    wdata_c     = store_rx_packet_data ? rx_packet_data : tx_data;
    empty_c     = (occ_q == '0);
    full_c      = (occ_q == FULL_CNT);
    pop_ok_c    = pop_req_c & ~empty_c;
    push_ok_c   = push_req_c & (~full_c | pop_ok_c);
    wr_en_c     = push_ok_c & ~flush_req_c;
  end

  // Next-state for pointers and occupancy; flush/clear overrides everything.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    if (flush_req_c) begin
      wptr_d = '0;
      rptr_d = '0;
      occ_d  = '0;
    end else begin
      if (push_ok_c) wptr_d = wptr_q + AW'(1);
      if (pop_ok_c)  rptr_d = rptr_q + AW'(1);
      case ({push_ok_c, pop_ok_c})
        2'b10:   occ_d = occ_q + OCC_W'(1);
        2'b01:   occ_d = occ_q - OCC_W'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
    end
  end

  // Byte storage; cleared only by reset, never by flush/clear.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= 8'h00;
    end else if (wr_en_c) begin
      mem_q[wptr_q] <= wdata_c;
    end
  end

  // Fall-through head byte, forced to zero while empty.
  always_comb begin
    head_c = empty_c ? 8'h00 : mem_q[rptr_q];
  end

  assign rx_data          = head_c;
  assign tx_packet_data   = head_c;
  assign buffer_occupancy = occ_q;

endmodule
